// File: rtl/gray_count_decoder.sv
// rtl/gray_count_decoder.sv - Gray count decoder with step-legality monitor, lock tracking and error counter
// Optional macro GRAY_BIDIR_EN: accepts single backward steps and adds dir_out.
module gray_count_decoder #(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             gray_valid,
   input  logic             clear_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_err,
   output logic             locked,
`ifdef GRAY_BIDIR_EN
   output logic             dir_out,
`endif
   output logic [ERR_W-1:0] err_count
);

   localparam int                CW      = 4;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [CW-1:0]    CNT_TOP = CW'(LOCK_CNT);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_ACQUIRE,
      ST_LOCKED
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] bin_q;
   logic             bin_valid_q;
   logic             step_err_q;
   logic             locked_q;
   logic [CW-1:0]    cnt_q;
   logic [ERR_W-1:0] err_q;
   logic [ERR_W-1:0] err_d;
   logic [WIDTH-1:0] bin_d;
   logic             step_fwd;
   logic             step_bwd;
   logic             step_hold;
   logic             step_bad;
   logic             count_err;
`ifdef GRAY_BIDIR_EN
   logic             dir_q;
`endif

   // bin_out always holds the last decoded sample, so it doubles as prev.
   always_comb begin
      bin_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin_d[i] = ^(gray_in >> i);
      end
      step_fwd  = (bin_d == bin_q + ONE);
`ifdef GRAY_BIDIR_EN
      step_bwd  = (bin_d == bin_q - ONE);
`else
      step_bwd  = 1'b0;
`endif
      step_hold = (bin_d == bin_q);
      step_bad  = !(step_fwd || step_bwd || step_hold);
      count_err = gray_valid && (state_q != ST_UNLOCKED) && step_bad;
      // Clear first, then count, so a same-cycle clear and error leaves 1.
      err_d = clear_err ? '0 : err_q;
      if (count_err && (err_d != ERR_MAX)) begin
         err_d = err_d + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_UNLOCKED;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         locked_q    <= 1'b0;
         cnt_q       <= '0;
         err_q       <= '0;
`ifdef GRAY_BIDIR_EN
         dir_q       <= 1'b1;
`endif
      end else begin
         bin_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         err_q       <= err_d;
         if (gray_valid) begin
            bin_q       <= bin_d;
            bin_valid_q <= 1'b1;
`ifdef GRAY_BIDIR_EN
            if (state_q != ST_UNLOCKED) begin
               if (step_fwd) begin
                  dir_q <= 1'b1;
               end else if (step_bwd) begin
                  dir_q <= 1'b0;
               end
            end
`endif
            case (state_q)
               ST_UNLOCKED: begin
                  state_q <= ST_ACQUIRE;
                  cnt_q   <= '0;
               end
               ST_ACQUIRE: begin
                  if (step_fwd || step_bwd) begin
                     cnt_q <= cnt_q + CW'(1);
                     if (cnt_q + CW'(1) == CNT_TOP) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else if (step_bad) begin
                     step_err_q <= 1'b1;
                     cnt_q      <= '0;
                  end
               end
               ST_LOCKED: begin
                  if (step_bad) begin
                     step_err_q <= 1'b1;
                     locked_q   <= 1'b0;
                     cnt_q      <= '0;
                     state_q    <= ST_ACQUIRE;
                  end
               end
               default: begin
                  state_q  <= ST_UNLOCKED;
                  locked_q <= 1'b0;
                  cnt_q    <= '0;
               end
            endcase
         end
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = bin_valid_q;
   assign step_err  = step_err_q;
   assign locked    = locked_q;
   assign err_count = err_q;
`ifdef GRAY_BIDIR_EN
   assign dir_out   = dir_q;
`endif

endmodule

// File: tb/tb_gray_count_decoder.sv
// tb/tb_gray_count_decoder.sv - Table-driven bench for gray_count_decoder
// Covers GRAY_BIDIR_EN when the macro is defined for both files.
module tb_gray_count_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] gray_in;
   logic       gray_valid;
   logic       clear_err;
   logic [2:0] bin_out;
   logic       bin_valid;
   logic       step_err;
   logic       locked;
   logic [7:0] err_count;
`ifdef GRAY_BIDIR_EN
   logic       dir_out;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   gray_count_decoder #(.WIDTH(3), .LOCK_CNT(4), .ERR_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .gray_in    (gray_in),
      .gray_valid (gray_valid),
      .clear_err  (clear_err),
      .bin_out    (bin_out),
      .bin_valid  (bin_valid),
      .step_err   (step_err),
      .locked     (locked),
`ifdef GRAY_BIDIR_EN
      .dir_out    (dir_out),
`endif
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [2:0] g;
      logic       v;
      logic       c;
      logic [2:0] bin;
      logic       bv;
      logic       se;
      logic       lk;
      logic [7:0] err;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [2:0] g, input logic v, input logic c,
                      input logic [2:0] bin, input logic bv, input logic se, input logic lk,
                      input logic [7:0] err);
      vec_t e;
      e.r = r; e.g = g; e.v = v; e.c = c;
      e.bin = bin; e.bv = bv; e.se = se; e.lk = lk; e.err = err;
      tbl.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic [2:0] g, input logic v, input logic c);
      rst = r; gray_in = g; gray_valid = v; clear_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] bin, input logic bv,
                            input logic se, input logic lk, input logic [7:0] err);
      check(name, {17'd0, bin_out, bin_valid, step_err, locked, err_count},
            {17'd0, bin, bv, se, lk, err});
   endtask

   initial begin
      rst = 1'b1; gray_in = 3'b101; gray_valid = 1'b1; clear_err = 1'b0;
      //  r  gray    v  c  bin   bv se lk err
      add(1, 3'b101, 1, 0, 3'd0, 0, 0, 0, 8'd0);
      add(1, 3'b101, 1, 0, 3'd0, 0, 0, 0, 8'd0);
      add(0, 3'b000, 1, 0, 3'd0, 1, 0, 0, 8'd0);
      add(0, 3'b001, 1, 0, 3'd1, 1, 0, 0, 8'd0);
      add(0, 3'b011, 1, 0, 3'd2, 1, 0, 0, 8'd0);
      add(0, 3'b010, 1, 0, 3'd3, 1, 0, 0, 8'd0);
      add(0, 3'b110, 1, 0, 3'd4, 1, 0, 1, 8'd0);
      add(0, 3'b111, 1, 0, 3'd5, 1, 0, 1, 8'd0);
      add(0, 3'b101, 1, 0, 3'd6, 1, 0, 1, 8'd0);
      add(0, 3'b100, 1, 0, 3'd7, 1, 0, 1, 8'd0);
      add(0, 3'b000, 1, 0, 3'd0, 1, 0, 1, 8'd0);
      add(0, 3'b001, 1, 0, 3'd1, 1, 0, 1, 8'd0);
      add(0, 3'b011, 1, 0, 3'd2, 1, 0, 1, 8'd0);
      add(0, 3'b110, 1, 0, 3'd4, 1, 1, 0, 8'd1);
      add(0, 3'b111, 1, 0, 3'd5, 1, 0, 0, 8'd1);
      add(0, 3'b101, 1, 0, 3'd6, 1, 0, 0, 8'd1);
      add(0, 3'b100, 1, 0, 3'd7, 1, 0, 0, 8'd1);
      add(0, 3'b000, 1, 0, 3'd0, 1, 0, 1, 8'd1);
      add(0, 3'b001, 1, 0, 3'd1, 1, 0, 1, 8'd1);
      add(0, 3'b011, 1, 0, 3'd2, 1, 0, 1, 8'd1);
      add(0, 3'b010, 1, 0, 3'd3, 1, 0, 1, 8'd1);
      add(0, 3'b010, 1, 0, 3'd3, 1, 0, 1, 8'd1);
      add(0, 3'b111, 0, 0, 3'd3, 0, 0, 1, 8'd1);
      add(0, 3'b000, 0, 0, 3'd3, 0, 0, 1, 8'd1);
      add(0, 3'b101, 0, 0, 3'd3, 0, 0, 1, 8'd1);
      add(0, 3'b110, 1, 0, 3'd4, 1, 0, 1, 8'd1);
      add(0, 3'b000, 1, 0, 3'd0, 1, 1, 0, 8'd2);
      add(0, 3'b000, 1, 0, 3'd0, 1, 0, 0, 8'd2);
      add(0, 3'b001, 1, 0, 3'd1, 1, 0, 0, 8'd2);
      add(0, 3'b001, 1, 0, 3'd1, 1, 0, 0, 8'd2);
      add(0, 3'b011, 1, 0, 3'd2, 1, 0, 0, 8'd2);
      add(0, 3'b010, 1, 0, 3'd3, 1, 0, 0, 8'd2);
      add(0, 3'b110, 1, 0, 3'd4, 1, 0, 1, 8'd2);
      add(0, 3'b000, 1, 0, 3'd0, 1, 1, 0, 8'd3);
      add(0, 3'b011, 1, 0, 3'd2, 1, 1, 0, 8'd4);
      add(0, 3'b000, 1, 0, 3'd0, 1, 1, 0, 8'd5);
      add(0, 3'b011, 1, 1, 3'd2, 1, 1, 0, 8'd1);
      add(0, 3'b011, 0, 1, 3'd2, 0, 0, 0, 8'd0);
      add(1, 3'b011, 1, 0, 3'd0, 0, 0, 0, 8'd0);
      add(0, 3'b110, 1, 0, 3'd4, 1, 0, 0, 8'd0);
      add(0, 3'b111, 1, 0, 3'd5, 1, 0, 0, 8'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].g, tbl[i].v, tbl[i].c);
         check_all($sformatf("vec%0d", i), tbl[i].bin, tbl[i].bv, tbl[i].se, tbl[i].lk,
                   tbl[i].err);
      end

      // Saturation: every sample of 0/2 alternation is an illegal step.
      for (int i = 0; i < 300; i++) begin
         cyc(1'b0, (i % 2 == 1) ? 3'b011 : 3'b000, 1'b1, 1'b0);
      end
      check_all("sat_300", 3'd2, 1'b1, 1'b1, 1'b0, 8'd255);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, (i % 2 == 1) ? 3'b011 : 3'b000, 1'b1, 1'b0);
      end
      check_all("sat_hold", 3'd2, 1'b1, 1'b1, 1'b0, 8'd255);
      cyc(1'b0, 3'b000, 1'b1, 1'b1);
      check_all("sat_clear_err", 3'd0, 1'b1, 1'b1, 1'b0, 8'd1);

      // Backward step 3 -> 2 directly after a reset.
      cyc(1'b1, 3'b000, 1'b0, 1'b0);
`ifdef GRAY_BIDIR_EN
      check("dir_rst", {31'd0, dir_out}, 32'd1);
`endif
      cyc(1'b0, 3'b010, 1'b1, 1'b0);
      check_all("bk_first", 3'd3, 1'b1, 1'b0, 1'b0, 8'd0);
      cyc(1'b0, 3'b011, 1'b1, 1'b0);
`ifdef GRAY_BIDIR_EN
      check_all("bk_step", 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
      check("dir_bk", {31'd0, dir_out}, 32'd0);
      cyc(1'b0, 3'b011, 1'b1, 1'b0);
      check("dir_hold", {31'd0, dir_out}, 32'd0);
      cyc(1'b0, 3'b010, 1'b1, 1'b0);
      check("dir_fwd", {31'd0, dir_out}, 32'd1);
      cyc(1'b0, 3'b011, 1'b1, 1'b0);
      check_all("bk_rev", 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
      cyc(1'b0, 3'b001, 1'b1, 1'b0);
      check_all("bk_lock", 3'd1, 1'b1, 1'b0, 1'b1, 8'd0);
      check("dir_bk2", {31'd0, dir_out}, 32'd0);
`else
      check_all("bk_illegal", 3'd2, 1'b1, 1'b1, 1'b0, 8'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Receiving end of the Gray-coded counter interface. Samples a WIDTH-bit Gray count, decodes it to binary, and checks that successive samples form legal single-step Gray transitions.
- Tracks lock to the incoming sequence, flags illegal steps and keeps a saturating error count.
- Sits downstream of any Gray counter, e.g. the modulo-8 counter after a clock-domain crossing, as decoder plus integrity monitor.

Parameters:
- WIDTH, 3, Gray/binary count width; modulus is 2**WIDTH.
- LOCK_CNT, 4, number of consecutive legal forward steps required to assert locked (1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- gray_in  in  WIDTH  Gray-coded count sample
- gray_valid  in  1  gray_in is meaningful this cycle
- clear_err  in  1  synchronous clear of err_count
- bin_out  out  WIDTH  decoded binary of last valid sample (registered)
- bin_valid  out  1  one-cycle pulse: bin_out updated this cycle
- step_err  out  1  one-cycle pulse: last valid sample was an illegal step
- locked  out  1  sequence tracking established
- err_count  out  ERR_W  saturating count of illegal steps

Behaviour:
- Reset: one clock, one synchronous active-high reset (rst).
  - While rst=1 at a rising edge: bin_out=0, bin_valid=0, step_err=0, locked=0, err_count=0, FSM=UNLOCKED, step counter=0.
  - Reset mid-operation discards all history; the next sample is treated as a first sample.
- Decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i].
- Latency: a sample with gray_valid=1 at edge N gives bin_out, bin_valid, step_err and locked updated at edge N. They are visible in cycle N+1.
  - gray_valid=0: bin_valid=0, step_err=0, all other state held.
- Step classification against the previously decoded binary value prev:
  - forward: b == (prev+1) mod 2**WIDTH. Wrap from 2**WIDTH-1 to 0 is legal.
  - hold: b == prev. No error, step counter unchanged.
  - illegal: anything else, including backward steps and multi-bit Gray changes.
- FSM states and transitions:
  - UNLOCKED: first valid sample latches prev=b with no error check, then goes to ACQUIRE with step counter=0.
  - ACQUIRE:
    - forward: step counter +1. When it reaches LOCK_CNT, go to LOCKED and set locked=1 on the same edge.
    - hold: stay.
    - illegal: step_err=1, err_count+1, prev=b, step counter=0, stay in ACQUIRE.
  - LOCKED:
    - forward or hold: stay, locked=1.
    - illegal: step_err=1, err_count+1, locked=0, step counter=0, go to ACQUIRE with prev=b.
- prev updates on every valid sample.
- err_count:
  - Saturates at 2**ERR_W-1.
  - clear_err=1 zeroes it. If an illegal step occurs in the same cycle, the result is 1: clear first, then count.
  - rst overrides everything.

Optional Feature:
- Macro: GRAY_BIDIR_EN.
- Defined:
  - Backward steps, b == (prev-1) mod 2**WIDTH including 0 to 2**WIDTH-1, are legal.
  - Backward steps count toward lock the same as forward steps.
  - Extra output port dir_out (out, 1) is registered: 1=last step forward, 0=last step backward. It holds on a hold step and resets to 1.
  - A direction reversal is legal.
- Undefined:
  - A backward step is illegal.
  - The dir_out port does not exist.

Test Plan:
- Reset: rst=1 for 2 cycles with gray_in=101, gray_valid=1 -> bin_out=000, bin_valid=0, step_err=0, locked=0, err_count=0.
- Acquire: after reset, drive gray 000,001,011,010,110 on consecutive cycles -> bin_out 0,1,2,3,4 with bin_valid pulses each cycle. locked=1 together with bin_out=4 (4th forward step). step_err never asserted.
- Wrap while locked: continue 111,101,100,000 -> bin_out 5,6,7,0, no step_err, locked stays 1.
- Skip error: locked at gray 011 (bin 2), drive 110 (bin 4) -> step_err pulse 1 cycle, err_count 0->1, locked=0. Then 111,101,100,000 -> locked=1 on the 4th.
- Holds and gaps: drive 010 twice, then gray_valid=0 for 3 cycles, then 110 -> no step_err; bin_valid low during the gap; locked unchanged; bin_out=4 after 110.
- Error counter:
  - clear_err=1 in the same cycle as an illegal step with err_count=5 -> err_count=1.
  - 300 alternating 000/011 samples -> err_count=255 and holds.
  - With GRAY_BIDIR_EN: 010 then 011 -> bin 3 then 2, no error, dir_out=0.
